// File: rtl/booth_pkg.sv
// ============================================================================
// Module      : booth_pkg
// Description : Shared FSM encodings and product-width constants for the
//               Booth multiplier and its downstream accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

    localparam int c_MULTIPLICAND_WIDTH = 8;
    localparam int c_MULTIPLIER_WIDTH   = 8;
    localparam int PROD_WIDTH           = c_MULTIPLICAND_WIDTH + c_MULTIPLIER_WIDTH;

    // Width of the {AC,QR} product for arbitrary operand widths.
    function automatic int prod_width(input int mcand_w, input int mplier_w);
        return mcand_w + mplier_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_sat_add.sv
// ============================================================================
// Module      : booth_sat_add
// Description : Combinational signed adder with overflow flag. With
//               BOOTH_ACC_SATURATE_EN defined the sum clamps on overflow,
//               otherwise it wraps (two's complement).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_sat_add #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_raw;

    assign w_raw = i_a + i_b;

    // Overflow: operands agree in sign, result does not.
    assign o_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_raw[WIDTH-1] != i_a[WIDTH-1]);

`ifdef BOOTH_ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] c_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    assign o_sum = o_ovf ? (i_a[WIDTH-1] ? c_MIN : c_MAX) : w_raw;
`else
    assign o_sum = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/booth_product_accumulator.sv
// ============================================================================
// Module      : booth_product_accumulator
// Description : Sums a burst of signed Booth products {AC,QR} into a wide
//               accumulator and presents the result over valid/ready.
//               Optional macro BOOTH_ACC_SATURATE_EN selects saturating adds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int MULTIPLICAND_WIDTH = 8,
    parameter int MULTIPLIER_WIDTH   = 8,
    parameter int ACC_WIDTH          = 24,
    parameter int COUNT_WIDTH        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MULTIPLICAND_WIDTH-1:0] ac,
    input  logic [MULTIPLIER_WIDTH-1:0]   qr,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_acc,
    output logic [COUNT_WIDTH-1:0]        out_count,
    output logic                          out_overflow
);

    localparam int c_PROD_WIDTH = prod_width(MULTIPLICAND_WIDTH, MULTIPLIER_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = COUNT_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_accepting;
    logic                    w_holding;
    logic                    w_beat;
    logic [c_PROD_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]    w_prod_ext;
    logic [ACC_WIDTH-1:0]    w_sum;
    logic                    w_add_ovf;
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    r_ovf;

    assign w_prod = {ac, qr};

    generate
        if (ACC_WIDTH > c_PROD_WIDTH) begin : g_sext
            assign w_prod_ext = {{(ACC_WIDTH-c_PROD_WIDTH){w_prod[c_PROD_WIDTH-1]}}, w_prod};
        end else begin : g_same
            assign w_prod_ext = w_prod;
        end
    endgenerate

    booth_sat_add #(
        .WIDTH (ACC_WIDTH)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    always_comb begin
        w_state_next = r_state;
        w_accepting  = 1'b0;
        w_holding    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accepting = 1'b1;
                if (in_valid) begin
                    w_state_next = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_accepting = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_holding = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted.
    assign in_ready  = w_accepting & ~rst;
    assign out_valid = w_holding & ~rst;
    assign w_beat    = in_valid & w_accepting;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_beat) begin
                if (r_state == ST_IDLE) begin
                    r_acc   <= w_prod_ext;
                    r_count <= c_COUNT_ONE;
                    r_ovf   <= 1'b0;
                end else begin
                    r_acc   <= w_sum;
                    r_count <= (r_count == '1) ? r_count : r_count + c_COUNT_ONE;
                    r_ovf   <= r_ovf | w_add_ovf;
                end
            end
        end
    end

    assign out_acc      = r_acc;
    assign out_count    = r_count;
    assign out_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_booth_product_accumulator.sv
// ============================================================================
// Module      : tb_booth_product_accumulator
// Description : Scoreboard bench driving two accumulator instances (24-bit
//               acc / 8-bit count and 16-bit acc / 2-bit count) in lockstep.
//               Honours BOOTH_ACC_SATURATE_EN for expected values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_product_accumulator;
    import booth_pkg::*;

    typedef struct packed {
        logic [23:0] acc_a;
        logic [7:0]  cnt_a;
        logic        ovf_a;
        logic [15:0] acc_b;
        logic [1:0]  cnt_b;
        logic        ovf_b;
        logic        v_b;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  ac = '0;
    logic [7:0]  qr = '0;

    logic        in_ready_a, out_valid_a, out_overflow_a;
    logic [23:0] out_acc_a;
    logic [7:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_overflow_b;
    logic [15:0] out_acc_b;
    logic [1:0]  out_count_b;

    int   n_vec = 0;
    int   n_err = 0;
    res_t sb_q[$];

    longint m_acc_a, m_acc_b;
    int     m_cnt_a, m_cnt_b;
    bit     m_ovf_a, m_ovf_b;
    bit     m_first = 1'b1;

    always #5 clk = ~clk;

    booth_product_accumulator #(
        .MULTIPLICAND_WIDTH (8), .MULTIPLIER_WIDTH (8), .ACC_WIDTH (24), .COUNT_WIDTH (8)
    ) u_dut_a (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready_a),
        .ac (ac), .qr (qr), .in_last (in_last), .out_valid (out_valid_a),
        .out_ready (out_ready), .out_acc (out_acc_a), .out_count (out_count_a),
        .out_overflow (out_overflow_a)
    );

    booth_product_accumulator #(
        .MULTIPLICAND_WIDTH (8), .MULTIPLIER_WIDTH (8), .ACC_WIDTH (16), .COUNT_WIDTH (2)
    ) u_dut_b (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready_b),
        .ac (ac), .qr (qr), .in_last (in_last), .out_valid (out_valid_b),
        .out_ready (out_ready), .out_acc (out_acc_b), .out_count (out_count_b),
        .out_overflow (out_overflow_b)
    );

    // Exact sum brought back into a W-bit signed range (wrap or clamp).
    function automatic longint fit(input longint s, input int w, output bit o);
        longint m, mx, mn;
        m  = longint'(1) << w;
        mx = (m >> 1) - 1;
        mn = -(m >> 1);
        o  = (s > mx) || (s < mn);
`ifdef BOOTH_ACC_SATURATE_EN
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
`else
        if (s > mx) return s - m;
        if (s < mn) return s + m;
        return s;
`endif
    endfunction

    function automatic res_t observe();
        res_t r;
        r.acc_a = out_acc_a;
        r.cnt_a = out_count_a;
        r.ovf_a = out_overflow_a;
        r.acc_b = out_acc_b;
        r.cnt_b = out_count_b;
        r.ovf_b = out_overflow_b;
        r.v_b   = out_valid_b;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_beat(input logic [PROD_WIDTH-1:0] p, input logic last);
        longint sp;
        bit     o;
        res_t   e;
        sp = longint'($signed(p));
        if (m_first) begin
            m_acc_a = sp; m_acc_b = sp;
            m_cnt_a = 1;  m_cnt_b = 1;
            m_ovf_a = 1'b0; m_ovf_b = 1'b0;
            m_first = 1'b0;
        end else begin
            m_acc_a = fit(m_acc_a + sp, 24, o); m_ovf_a = m_ovf_a | o;
            m_acc_b = fit(m_acc_b + sp, 16, o); m_ovf_b = m_ovf_b | o;
            m_cnt_a = (m_cnt_a == 255) ? 255 : m_cnt_a + 1;
            m_cnt_b = (m_cnt_b == 3) ? 3 : m_cnt_b + 1;
        end
        if (last) begin
            e.acc_a = m_acc_a[23:0];
            e.cnt_a = m_cnt_a[7:0];
            e.ovf_a = m_ovf_a;
            e.acc_b = m_acc_b[15:0];
            e.cnt_b = m_cnt_b[1:0];
            e.ovf_b = m_ovf_b;
            e.v_b   = 1'b1;
            sb_q.push_back(e);
            m_first = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [PROD_WIDTH-1:0] p, input logic last);
        int n;
        in_valid = 1'b1;
        {ac, qr} = p;
        in_last  = last;
        n = 0;
        while (!in_ready_a && n < 50) begin
            step();
            n++;
        end
        n_vec++;
        if (in_ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL send_beat: in_ready=%b required 1 within 50 cycles", in_ready_a);
        end else begin
            model_beat(p, last);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid_a && n < 50) begin
            step();
            n++;
        end
        n_vec++;
        if (out_valid_a !== 1'b1) begin
            n_err++;
            $display("FAIL %s wait: out_valid=%b required 1", tag, out_valid_a);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        n_vec++;
        if ({in_ready_a, out_valid_a, in_ready_b, out_valid_b} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hs: got %b required 0000", {in_ready_a, out_valid_a, in_ready_b, out_valid_b});
        end
        n_vec++;
        if (observe() !== '0) begin
            n_err++;
            $display("FAIL reset_out: got %h required 0", observe());
        end
        rst = 1'b0;
        #1;
        m_first = 1'b1;
        sb_q.delete();
        n_vec++;
        if ({in_ready_a, out_valid_a} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release: ready/valid=%b required 10", {in_ready_a, out_valid_a});
        end
    endtask

    task automatic test_single_beat();
        res_t e;
        send_beat(16'h0200, 1'b1);
        n_vec++;
        if (out_valid_a !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency: out_valid=%b required 1", out_valid_a);
        end
        wait_valid("single");
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_vec++;
        if (observe() !== e || out_acc_a !== 24'd512 || out_count_a !== 8'd1) begin
            n_err++;
            $display("FAIL single: got %h required %h (acc 512 cnt 1)", observe(), e);
        end
        release_result();
        n_vec++;
        if ({in_ready_a, out_valid_a} !== 2'b10) begin
            n_err++;
            $display("FAIL single_release: ready/valid=%b required 10", {in_ready_a, out_valid_a});
        end
    endtask

    task automatic test_burst_backpressure();
        res_t e;
        send_beat(16'h0200, 1'b0);
        send_beat(16'h05DC, 1'b0);
        send_beat(16'hFFFF, 1'b1);
        wait_valid("burst3");
        e = (sb_q.size() > 0) ? sb_q[0] : '0;
        n_vec++;
        if (observe() !== e || out_acc_a !== 24'd2011 || out_count_a !== 8'd3 || out_overflow_a !== 1'b0) begin
            n_err++;
            $display("FAIL burst3: got %h required %h (acc 2011 cnt 3)", observe(), e);
        end
        in_valid = 1'b1; {ac, qr} = 16'h0003; in_last = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || observe() !== e) begin
                n_err++;
                $display("FAIL backpressure cyc%0d: rdy=%b vld=%b out=%h required 0 1 %h",
                         i, in_ready_a, out_valid_a, observe(), e);
            end
        end
        release_result();
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        n_vec++;
        if ({in_ready_a, out_valid_a} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_release: ready/valid=%b required 10", {in_ready_a, out_valid_a});
        end
        send_beat(16'h0003, 1'b1);
        n_vec++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        if (out_valid_a !== 1'b1 || observe() !== e || out_acc_a !== 24'd3) begin
            n_err++;
            $display("FAIL bp_next: vld=%b out=%h required 1 %h", out_valid_a, observe(), e);
        end
        release_result();
    endtask

    task automatic test_overflow();
        res_t e;
        logic [15:0] want_b;
`ifdef BOOTH_ACC_SATURATE_EN
        want_b = 16'h7FFF;
`else
        want_b = 16'h8000;
`endif
        send_beat(16'h7FFF, 1'b0);
        send_beat(16'h0001, 1'b1);
        wait_valid("ovf_pos");
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_vec++;
        if (observe() !== e || out_acc_b !== want_b || out_overflow_b !== 1'b1
            || out_acc_a !== 24'h008000 || out_overflow_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_pos: got %h required %h (acc16 %h ovf 1)", observe(), e, want_b);
        end
        release_result();
        // Negative overflow followed by a beat continuing from the wrapped/clamped value.
        send_beat(16'h8000, 1'b0);
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'h0001, 1'b1);
        wait_valid("ovf_neg");
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_vec++;
        if (observe() !== e) begin
            n_err++;
            $display("FAIL ovf_neg: got %h required %h", observe(), e);
        end
        release_result();
    endtask

    task automatic test_reset_mid_burst();
        res_t e;
        send_beat(16'h1234, 1'b0);
        send_beat(16'h0100, 1'b0);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({in_ready_a, out_valid_a, in_ready_b, out_valid_b} !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst_hs: got %b required 0000", {in_ready_a, out_valid_a, in_ready_b, out_valid_b});
        end
        step();
        rst = 1'b0;
        #1;
        m_first = 1'b1;
        n_vec++;
        if (observe() !== '0 || in_ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_clear: got %h rdy=%b required 0 rdy=1", observe(), in_ready_a);
        end
        send_beat(16'h0001, 1'b1);
        wait_valid("midrst");
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_vec++;
        if (observe() !== e || out_acc_a !== 24'd1 || out_count_a !== 8'd1) begin
            n_err++;
            $display("FAIL midrst_burst: got %h required %h (acc 1 cnt 1)", observe(), e);
        end
        release_result();
    endtask

    task automatic test_count_sat();
        res_t e;
        for (int i = 0; i < 5; i++) send_beat(16'h0001, (i == 4));
        wait_valid("cntsat");
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_vec++;
        if (observe() !== e || out_count_b !== 2'd3 || out_acc_b !== 16'd5 || out_count_a !== 8'd5) begin
            n_err++;
            $display("FAIL cntsat: got %h required %h (cnt2 3 acc 5)", observe(), e);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        res_t e;
        int   len;
        for (int b = 0; b < 8; b++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) send_beat(16'($urandom), (i == len - 1));
            wait_valid("b2b");
            repeat ($urandom_range(0, 2)) step();
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_vec++;
            if (observe() !== e) begin
                n_err++;
                $display("FAIL b2b burst%0d: got %h required %h", b, observe(), e);
            end
            release_result();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_burst_backpressure();
        test_overflow();
        test_reset_mid_burst();
        test_count_sat();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
